scoreboard_hazard_unit: RTL and testbench
=========================================

Name: scoreboard_hazard_unit

Overview:
- Producer-side companion to the EX/ID forwarding logic.
- Tracks destination registers of in-flight long-latency ops (loads, NIC reads, multi-cycle multiply) in a 32-entry pending scoreboard.
- Stalls the ID stage when a source operand or destination register depends on a result that cannot yet be forwarded.
- Sits between ID issue and the writeback port of the long-latency units; also reports stall-timeout errors.

Parameters:
- MAX_OUTSTANDING, 4, maximum number of long ops in flight at once.
- TIMEOUT_CYCLES, 256, consecutive stall cycles before timeout_error is set.
- CNT_W, 3, width of outstanding_count; must satisfy 2^CNT_W > MAX_OUTSTANDING.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-high reset.
- id_rA_address  input  [0:4]  ID source A register.
- id_rA_used  input  1  ID instruction reads rA.
- id_rB_address  input  [0:4]  ID source B register.
- id_rB_used  input  1  ID instruction reads rB.
- id_issue_valid  input  1  ID holds a valid instruction that writes id_rD_address.
- id_rD_address  input  [0:4]  ID destination register.
- id_issue_long  input  1  instruction is a long-latency op.
- wb_valid  input  1  a long op completes this cycle.
- wb_rD_address  input  [0:4]  destination register of the completing long op.
- stall  output  1  hold PC/IF/ID and inject a bubble into EX; combinational.
- pending_vector  output  [0:31]  registered scoreboard; bit i = register i pending.
- outstanding_count  output  [0:CNT_W-1]  long ops in flight.
- timeout_error  output  1  sticky error flag.

Behaviour:
- Reset (async, any time, including mid-stall): pending_vector=0, outstanding_count=0, stall_cycles=0, timeout_error=0, state=RUN. stall is combinational and is 0 once the registers are cleared, given its inputs.
- Effective pending: pend_eff[r] = pending_vector[r] & ~(wb_valid & wb_rD_address==r). A same-cycle writeback removes the hazard; the result is forwarded by WB.
- Register 0 is never pending and never causes a stall.
- stall = 1 if any of the following holds:
  - id_rA_used & rA!=0 & pend_eff[rA]
  - id_rB_used & rB!=0 & pend_eff[rB]
  - id_issue_valid & rD!=0 & pend_eff[rD] (WAW)
  - id_issue_valid & id_issue_long & outstanding_count==MAX_OUTSTANDING & ~wb_valid
- accept = id_issue_valid & id_issue_long & ~stall.
- Scoreboard update at clk rising edge:
  - Clear bit wb_rD_address if wb_valid and address!=0.
  - Set bit id_rD_address if accept and address!=0.
  - Set and clear of the same bit in the same cycle: set wins, so the bit stays 1.
- outstanding_count:
  - +1 on accept; -1 on wb_valid; both in one cycle: unchanged.
  - Decrement saturates at 0. An increment at MAX_OUTSTANDING is impossible because stall blocks it.
  - A long op to r0 is counted but sets no pending bit.
- Stall latency: 0 cycles, same-cycle combinational. Scoreboard visibility: 1 cycle after issue.
- FSM, state register plus stall_cycles counter of width ceil(log2(TIMEOUT_CYCLES+1)):
  - RUN: stall=1 moves to STALL with stall_cycles=1.
  - STALL: stall=1 increments stall_cycles. When stall_cycles reaches TIMEOUT_CYCLES, go to ERROR and set timeout_error. stall=0 returns to RUN and clears stall_cycles.
  - ERROR: timeout_error held at 1. stall output continues functioning normally. The scoreboard keeps updating. Only reset exits ERROR.
- No handshake retry: the ID stage must keep its inputs stable while stall=1.

Test Plan:
- Reset, then issue a long op to r5. Next cycle ID reads rA=5 with rA_used=1 -> stall=1, pending_vector bit5=1, count=1. Apply wb_valid with wb_rD=5 -> stall=0 in that same cycle; bit5=0 and count=0 after the edge.
- Issue a long op to r0, then ID reads rA=0 -> no stall, pending_vector=0, count=1. Apply wb_valid with wb_rD=0 -> count=0.
- Issue 4 long ops to r1..r4 back-to-back, then a 5th to r6 -> stall=1 with count=4. Assert wb_valid with wb_rD=1 in the same cycle -> stall=0, issue accepted, count stays 4, bit1=0, bit6=1.
- With r7 pending, assert wb_valid wb_rD=7 and accept a new long issue to r7 in the same cycle -> bit7 remains 1, count unchanged.
- Hold a dependency on r9 with no writeback for 256 cycles -> timeout_error=1 at cycle 256 and stays 1 after wb clears r9 and stall drops. Asserting reset mid-stall -> all outputs 0 immediately.
- WAW: r3 pending, ID issues a short op to rD=3 with no source hazard -> stall=1. Clear r3 by writeback -> stall=0 that cycle.

Source files
------------

// File: rtl/scoreboard_hazard_unit.sv
// rtl/scoreboard_hazard_unit.sv - pending-register scoreboard and ID stall unit for long-latency ops
module scoreboard_hazard_unit #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256,
  parameter int CNT_W           = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:4]       id_rA_address,
  input  logic             id_rA_used,
  input  logic [0:4]       id_rB_address,
  input  logic             id_rB_used,
  input  logic             id_issue_valid,
  input  logic [0:4]       id_rD_address,
  input  logic             id_issue_long,
  input  logic             wb_valid,
  input  logic [0:4]       wb_rD_address,
  output logic             stall,
  output logic [0:31]      pending_vector,
  output logic [0:CNT_W-1] outstanding_count,
  output logic             timeout_error
);

  localparam int SC_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [SC_W-1:0]  stall_cycles;
  logic [SC_W-1:0]  cycles_next;
  logic [SC_W-1:0]  cycles_inc;

  logic [0:31]      pend_eff;
  logic [0:31]      pending_next;
  logic [0:CNT_W-1] count_next;

  logic             raw_a;
  logic             raw_b;
  logic             waw;
  logic             full;
  logic             accept;

  // A register completing this cycle is forwarded by WB, so it no longer blocks ID; r0 never blocks.
  always_comb begin
    pend_eff = '0;
    for (int i = 1; i < 32; i++) begin
      pend_eff[i] = pending_vector[i] & ~(wb_valid && (wb_rD_address == 5'(i)));
    end
  end

  // Hazard detection: RAW on either source, WAW on the destination, or no free long-op slot.
  always_comb begin
    raw_a  = id_rA_used && (id_rA_address != 5'd0) && pend_eff[id_rA_address];
    raw_b  = id_rB_used && (id_rB_address != 5'd0) && pend_eff[id_rB_address];
    waw    = id_issue_valid && (id_rD_address != 5'd0) && pend_eff[id_rD_address];
    full   = id_issue_valid && id_issue_long &&
             (outstanding_count == CNT_W'(MAX_OUTSTANDING)) && !wb_valid;
    stall  = raw_a || raw_b || waw || full;
    accept = id_issue_valid && id_issue_long && !stall;
  end

  // Next scoreboard: clear the completing register first so a same-cycle re-issue wins.
  always_comb begin
    pending_next = pending_vector;
    if (wb_valid && (wb_rD_address != 5'd0)) begin
      pending_next[wb_rD_address] = 1'b0;
    end
    if (accept && (id_rD_address != 5'd0)) begin
      pending_next[id_rD_address] = 1'b1;
    end
  end

  // Next in-flight count: issue and completion in one cycle cancel; completion never underflows.
  always_comb begin
    count_next = outstanding_count;
    if (accept && !wb_valid) begin
      count_next = outstanding_count + 1'b1;
    end else if (!accept && wb_valid && (outstanding_count != '0)) begin
      count_next = outstanding_count - 1'b1;
    end
  end

  // Scoreboard and in-flight counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_vector    <= '0;
      outstanding_count <= '0;
    end else begin
      pending_vector    <= pending_next;
      outstanding_count <= count_next;
    end
  end

  // Stall watchdog next state: count consecutive stalled cycles, trap in ERROR on timeout.
  always_comb begin
    state_next  = state;
    cycles_next = stall_cycles;
    cycles_inc  = stall_cycles + 1'b1;
    case (state)
      RUN: begin
        if (stall) begin
          cycles_next = SC_W'(1);
          state_next  = (TIMEOUT_CYCLES <= 1) ? ERROR : STALL;
        end
      end
      STALL: begin
        if (stall) begin
          cycles_next = cycles_inc;
          if (cycles_inc >= SC_W'(TIMEOUT_CYCLES)) begin
            state_next = ERROR;
          end
        end else begin
          cycles_next = '0;
          state_next  = RUN;
        end
      end
      ERROR: begin
        state_next = ERROR;
      end
      default: begin
        state_next  = RUN;
        cycles_next = '0;
      end
    endcase
  end

  // Watchdog state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      stall_cycles <= '0;
    end else begin
      state        <= state_next;
      stall_cycles <= cycles_next;
    end
  end

  assign timeout_error = (state == ERROR);

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// tb/tb_scoreboard_hazard_unit.sv - directed bench with behavioural scoreboard model for scoreboard_hazard_unit
module tb_scoreboard_hazard_unit;

  logic       clk;
  logic       reset;
  logic [0:4] id_rA_address;
  logic       id_rA_used;
  logic [0:4] id_rB_address;
  logic       id_rB_used;
  logic       id_issue_valid;
  logic [0:4] id_rD_address;
  logic       id_issue_long;
  logic       wb_valid;
  logic [0:4] wb_rD_address;
  logic       stall;
  logic [0:31] pending_vector;
  logic [0:2] outstanding_count;
  logic       timeout_error;

  int pass_count;
  int check_count;

  scoreboard_hazard_unit #(
    .MAX_OUTSTANDING(4),
    .TIMEOUT_CYCLES(256),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_rA_address(id_rA_address),
    .id_rA_used(id_rA_used),
    .id_rB_address(id_rB_address),
    .id_rB_used(id_rB_used),
    .id_issue_valid(id_issue_valid),
    .id_rD_address(id_rD_address),
    .id_issue_long(id_issue_long),
    .wb_valid(wb_valid),
    .wb_rD_address(wb_rD_address),
    .stall(stall),
    .pending_vector(pending_vector),
    .outstanding_count(outstanding_count),
    .timeout_error(timeout_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT scoreboard re-indexed so bit r means register r.
  logic [31:0] dut_pend;
  always_comb begin
    dut_pend = '0;
    for (int i = 0; i < 32; i++) dut_pend[i] = pending_vector[i];
  end

  // Reference model: set of pending registers, number of ops in flight, stall run length, error flag.
  logic [31:0] m_pend;
  int          m_cnt;
  int          m_run;
  bit          m_err;

  function automatic bit blocks(input int r);
    return (r != 0) && m_pend[r] && !(wb_valid && (int'(wb_rD_address) == r));
  endfunction

  function automatic bit m_stall();
    return (id_rA_used && blocks(int'(id_rA_address))) ||
           (id_rB_used && blocks(int'(id_rB_address))) ||
           (id_issue_valid && blocks(int'(id_rD_address))) ||
           (id_issue_valid && id_issue_long && m_cnt == 4 && !wb_valid);
  endfunction

  function automatic bit m_accept();
    return id_issue_valid && id_issue_long && !m_stall();
  endfunction

  function automatic logic [31:0] m_next_pend();
    logic [31:0] p;
    p = m_pend;
    if (wb_valid && wb_rD_address != 5'd0) p[int'(wb_rD_address)] = 1'b0;
    if (m_accept() && id_rD_address != 5'd0) p[int'(id_rD_address)] = 1'b1;
    return p;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend <= '0;
      m_cnt  <= 0;
      m_run  <= 0;
      m_err  <= 1'b0;
    end else begin
      m_pend <= m_next_pend();
      if (m_accept() && !wb_valid) m_cnt <= m_cnt + 1;
      else if (!m_accept() && wb_valid && m_cnt > 0) m_cnt <= m_cnt - 1;
      if (!m_err) begin
        if (m_stall()) begin
          m_run <= m_run + 1;
          if (m_run + 1 >= 256) m_err <= 1'b1;
        end else begin
          m_run <= 0;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    check_count++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else pass_count++;
  endtask

  // Per-cycle comparison against the model, mid-cycle while inputs are stable.
  always @(negedge clk) begin
    check("cyc_stall", int'(stall), int'(m_stall()));
    if (dut_pend != m_pend) begin
      check_count++;
      $display("FAIL cyc_pending: got %h expected %h at %0t", dut_pend, m_pend, $time);
    end else begin
      check_count++;
      pass_count++;
    end
    check("cyc_count", int'(outstanding_count), m_cnt);
    check("cyc_timeout", int'(timeout_error), int'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int ra, input bit rau, input int rb, input bit rbu,
                     input bit iv, input int rd, input bit il, input bit wv, input int wrd);
    id_rA_address  = 5'(ra);
    id_rA_used     = rau;
    id_rB_address  = 5'(rb);
    id_rB_used     = rbu;
    id_issue_valid = iv;
    id_rD_address  = 5'(rd);
    id_issue_long  = il;
    wb_valid       = wv;
    wb_rD_address  = 5'(wrd);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    pass_count  = 0;
    check_count = 0;
    reset = 1'b1;
    idle();
    #12;
    check("rst_stall", int'(stall), 0);
    check("rst_pending", int'(dut_pend != 0), 0);
    check("rst_count", int'(outstanding_count), 0);
    check("rst_timeout", int'(timeout_error), 0);
    reset = 1'b0;
    tick();

    // RAW on r5, cleared by same-cycle writeback
    drv(0, 0, 0, 0, 1, 5, 1, 0, 0); tick();
    drv(5, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    check("s1_stall", int'(stall), 1);
    check("s1_bit5", int'(dut_pend[5]), 1);
    check("s1_count", int'(outstanding_count), 1);
    drv(5, 1, 0, 0, 0, 0, 0, 1, 5); #1;
    check("s1_wb_stall", int'(stall), 0);
    tick(); idle(); #1;
    check("s1_bit5_clr", int'(dut_pend[5]), 0);
    check("s1_count_clr", int'(outstanding_count), 0);

    // long op to r0: counted, never pending
    drv(0, 0, 0, 0, 1, 0, 1, 0, 0); tick();
    drv(0, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    check("s2_stall", int'(stall), 0);
    check("s2_pending", int'(dut_pend), 0);
    check("s2_count", int'(outstanding_count), 1);
    drv(0, 1, 0, 0, 0, 0, 0, 1, 0); tick(); idle(); #1;
    check("s2_count_clr", int'(outstanding_count), 0);

    // fill to MAX_OUTSTANDING, then a same-cycle writeback frees a slot
    for (int k = 1; k <= 4; k++) begin
      drv(0, 0, 0, 0, 1, k, 1, 0, 0); tick();
    end
    drv(0, 0, 0, 0, 1, 6, 1, 0, 0); #1;
    check("s3_full_stall", int'(stall), 1);
    check("s3_full_count", int'(outstanding_count), 4);
    drv(0, 0, 0, 0, 1, 6, 1, 1, 1); #1;
    check("s3_wb_stall", int'(stall), 0);
    tick(); idle(); #1;
    check("s3_count", int'(outstanding_count), 4);
    check("s3_bit1", int'(dut_pend[1]), 0);
    check("s3_bit6", int'(dut_pend[6]), 1);
    check("s3_pending", int'(dut_pend), 32'h0000_005C);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 2); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 3); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 4); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 6); tick();
    idle(); #1;
    check("s3_drain", int'(outstanding_count), 0);

    // set wins over clear on r7
    drv(0, 0, 0, 0, 1, 7, 1, 0, 0); tick();
    drv(0, 0, 0, 0, 1, 7, 1, 1, 7); #1;
    check("s4_stall", int'(stall), 0);
    tick(); idle(); #1;
    check("s4_bit7", int'(dut_pend[7]), 1);
    check("s4_count", int'(outstanding_count), 1);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 7); tick(); idle(); #1;
    check("s4_drain", int'(outstanding_count), 0);

    // WAW on r3 from a short op
    drv(0, 0, 0, 0, 1, 3, 1, 0, 0); tick();
    drv(0, 0, 0, 0, 1, 3, 0, 0, 0); #1;
    check("s6_waw_stall", int'(stall), 1);
    drv(0, 0, 0, 0, 1, 3, 0, 1, 3); #1;
    check("s6_wb_stall", int'(stall), 0);
    tick(); idle(); #1;
    check("s6_pending", int'(dut_pend), 0);
    check("s6_count", int'(outstanding_count), 0);

    // stall timeout on r9
    drv(0, 0, 0, 0, 1, 9, 1, 0, 0); tick();
    drv(9, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (255) tick();
    check("s5_before_timeout", int'(timeout_error), 0);
    tick();
    check("s5_timeout", int'(timeout_error), 1);
    drv(9, 1, 0, 0, 0, 0, 0, 1, 9); #1;
    check("s5_wb_stall", int'(stall), 0);
    tick(); idle(); #1;
    check("s5_sticky", int'(timeout_error), 1);
    check("s5_pending", int'(dut_pend), 0);

    // reset while stalled clears everything immediately
    drv(0, 0, 0, 0, 1, 9, 1, 0, 0); tick();
    drv(9, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check("s7_pre_stall", int'(stall), 1);
    reset = 1'b1; #1;
    check("s7_rst_stall", int'(stall), 0);
    check("s7_rst_pending", int'(dut_pend), 0);
    check("s7_rst_count", int'(outstanding_count), 0);
    check("s7_rst_timeout", int'(timeout_error), 0);
    tick();
    reset = 1'b0;
    idle();
    repeat (2) tick();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
